// File: rtl/core_clk_reset_sequencer.sv
// Core clock PLL supervisor and staggered per-domain reset release sequencer.
// Runs on the free-running reference clock. Holds the PLL in reset and waits
// for a stable lock. It then releases the domain reset requests one at a
// time, bit 0 first. A lock drop during release or run restarts the sequence.
// Ports:
//   refclk        free-running reference clock
//   rst           async active-high reset
//   locked        PLL lock indication, asynchronous to refclk
//   pll_rst       reset to the PLL, active-high
//   domain_rst    per-domain reset requests, active-high
//   ready         all domains released and lock healthy
//   lock_loss_cnt lock drops seen in RELEASE/RUN, saturating
//   timeout_cnt   lock attempts that timed out, saturating
module core_clk_reset_sequencer #(
    parameter int unsigned NUM_DOMAINS        = 4,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 64,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    output logic [CNT_W-1:0]       timeout_cnt
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The shared timer never exceeds (longest phase length - 1).
    localparam int unsigned RELEASE_CYCLES = STAGGER_CYCLES * NUM_DOMAINS;
    localparam int unsigned TMR_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                            max_u(LOCK_STABLE_CYCLES, RELEASE_CYCLES));
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RELEASE_LAST = TMR_W'(RELEASE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [2:0]             state,  state_n;
    logic [TMR_W-1:0]       timer,  timer_n;
    logic                   pll_rst_n;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   ready_n;
    logic [CNT_W-1:0]       lock_loss_cnt_n;
    logic [CNT_W-1:0]       timeout_cnt_n;

    // Lock synchroniser; nothing downstream looks at the raw locked input.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // State, timer, registered outputs and counters.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= ST_PLL_RST;
            timer         <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            pll_rst       <= pll_rst_n;
            domain_rst    <= domain_rst_n;
            ready         <= ready_n;
            lock_loss_cnt <= lock_loss_cnt_n;
            timeout_cnt   <= timeout_cnt_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n         = state;
        timer_n         = timer;
        pll_rst_n       = pll_rst;
        domain_rst_n    = domain_rst;
        ready_n         = ready;
        lock_loss_cnt_n = lock_loss_cnt;
        timeout_cnt_n   = timeout_cnt;

        case (state)
            ST_PLL_RST: begin
                // locked is deliberately ignored until the pulse completes.
                pll_rst_n = 1'b1;
                if (timer == PLL_RST_LAST) begin
                    state_n   = ST_WAIT_LOCK;
                    timer_n   = '0;
                    pll_rst_n = 1'b0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                pll_rst_n = 1'b0;
                if (locked_s) begin
                    state_n = ST_STABLE;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_n       = ST_PLL_RST;
                    timer_n       = '0;
                    pll_rst_n     = 1'b1;
                    timeout_cnt_n = sat_inc(timeout_cnt);
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            ST_STABLE: begin
                // A drop here is not a lock loss: simply wait for lock again.
                if (!locked_s) begin
                    state_n = ST_WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == STABLE_LAST) begin
                    state_n = ST_RELEASE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!locked_s) begin
                    state_n         = ST_PLL_RST;
                    timer_n         = '0;
                    pll_rst_n       = 1'b1;
                    domain_rst_n    = '1;
                    ready_n         = 1'b0;
                    lock_loss_cnt_n = sat_inc(lock_loss_cnt);
                end else if (state == ST_RELEASE) begin
                    // Bit i drops at timer == STAGGER*(i+1)-1; cleared bits stay cleared.
                    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (timer == TMR_W'(STAGGER_CYCLES * (i + 1) - 1)) begin
                            domain_rst_n[i] = 1'b0;
                        end
                    end
                    if (timer == RELEASE_LAST) begin
                        state_n      = ST_RUN;
                        timer_n      = '0;
                        domain_rst_n = '0;
                        ready_n      = 1'b1;
                    end else begin
                        timer_n = timer + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_n      = ST_PLL_RST;
                timer_n      = '0;
                pll_rst_n    = 1'b1;
                domain_rst_n = '1;
                ready_n      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_clk_reset_sequencer.sv
// Self-checking bench for core_clk_reset_sequencer with small parameters.
// A phase/elapsed-cycle reference model predicts every output each cycle;
// vector table, hand sequences and random lock patterns drive the DUT.
module tb_core_clk_reset_sequencer;

    localparam int unsigned NUM_DOMAINS        = 4;
    localparam int unsigned SYNC_STAGES        = 2;
    localparam int unsigned PLL_RST_CYCLES     = 4;
    localparam int unsigned LOCK_TIMEOUT       = 50;
    localparam int unsigned LOCK_STABLE_CYCLES = 8;
    localparam int unsigned STAGGER_CYCLES     = 4;
    localparam int unsigned CNT_W              = 2;

    localparam int ALL_DOM = (1 << NUM_DOMAINS) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int P_PLL  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;

    logic                   refclk;
    logic                   rst;
    logic                   locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   ready;
    logic [CNT_W-1:0]       lock_loss_cnt;
    logic [CNT_W-1:0]       timeout_cnt;

    core_clk_reset_sequencer #(
        .NUM_DOMAINS        (NUM_DOMAINS),
        .SYNC_STAGES        (SYNC_STAGES),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT       (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .STAGGER_CYCLES     (STAGGER_CYCLES),
        .CNT_W              (CNT_W)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked        (locked),
        .pll_rst       (pll_rst),
        .domain_rst    (domain_rst),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: phase, edges elapsed in phase, counters, sync pipeline.
    int m_phase;
    int m_e;
    int m_ll;
    int m_tc;
    bit q[$];

    typedef struct {
        int       d;        // locked is high for steps > d
        int       drop_at;  // step with locked forced low (0 = none)
        int       n;        // steps to run after reset
        logic [3:0] dom;
        logic     rdy;
        int       ll;
        int       tc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_PLL;
        m_e     = 0;
        m_ll    = 0;
        m_tc    = 0;
        q.delete();
        for (int i = 0; i < int'(SYNC_STAGES); i++) q.push_back(1'b0);
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_loss();
        m_phase = P_PLL;
        m_e     = 0;
        m_ll    = sat(m_ll + 1);
    endtask

    task automatic model_edge();
        bit ls;
        ls = q.pop_front();
        q.push_back(locked);
        case (m_phase)
            P_PLL: begin
                m_e++;
                if (m_e == int'(PLL_RST_CYCLES)) begin m_phase = P_WAIT; m_e = 0; end
            end
            P_WAIT: begin
                if (ls) begin
                    m_phase = P_STAB; m_e = 0;
                end else begin
                    m_e++;
                    if (m_e == int'(LOCK_TIMEOUT)) begin
                        m_phase = P_PLL; m_e = 0; m_tc = sat(m_tc + 1);
                    end
                end
            end
            P_STAB: begin
                if (!ls) begin
                    m_phase = P_WAIT; m_e = 0;
                end else begin
                    m_e++;
                    if (m_e == int'(LOCK_STABLE_CYCLES)) begin m_phase = P_REL; m_e = 0; end
                end
            end
            P_REL: begin
                if (!ls) model_loss();
                else begin
                    m_e++;
                    if (m_e == int'(STAGGER_CYCLES * NUM_DOMAINS)) begin m_phase = P_RUN; m_e = 0; end
                end
            end
            default: begin
                if (!ls) model_loss();
            end
        endcase
    endtask

    function automatic int exp_dom();
        int rel;
        if (m_phase == P_RUN) return 0;
        if (m_phase == P_REL) begin
            rel = m_e / int'(STAGGER_CYCLES);
            return ALL_DOM & ~((1 << rel) - 1);
        end
        return ALL_DOM;
    endfunction

    task automatic check_model();
        chk("pll_rst", int'(pll_rst), (m_phase == P_PLL) ? 1 : 0);
        chk("domain_rst", int'(domain_rst), exp_dom());
        chk("ready", int'(ready), (m_phase == P_RUN) ? 1 : 0);
        chk("lock_loss_cnt", int'(lock_loss_cnt), m_ll);
        chk("timeout_cnt", int'(timeout_cnt), m_tc);
    endtask

    // One refclk cycle: drive locked after the falling edge, check after the next one.
    task automatic step(input logic lk);
        locked = lk;
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        check_model();
    endtask

    // Pulse rst between edges and check outputs before any rising edge occurs.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_domain_rst", int'(domain_rst), ALL_DOM);
        chk("rst_ready", int'(ready), 0);
        chk("rst_lock_loss_cnt", int'(lock_loss_cnt), 0);
        chk("rst_timeout_cnt", int'(timeout_cnt), 0);
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 100) begin
            step(1'b1);
            n++;
        end
        chk("wait_ready", int'(ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_at[NUM_DOMAINS];
        int ready_at;
        int nhigh;
        int lat;
        int seg_left;
        logic lvl;

        rst    = 1'b0;
        locked = 1'b0;
        model_reset();

        tbl[0]  = '{10,   0,  40, 4'b0000, 1'b1, 0, 0};
        tbl[1]  = '{0,    0,  30, 4'b0000, 1'b1, 0, 0};
        tbl[2]  = '{10,   0,  30, 4'b1100, 1'b0, 0, 0};
        tbl[3]  = '{1000, 0,  60, 4'b1111, 1'b0, 0, 1};
        tbl[4]  = '{1000, 0, 120, 4'b1111, 1'b0, 0, 2};
        tbl[5]  = '{10,  16,  42, 4'b1000, 1'b0, 0, 0};
        tbl[6]  = '{0,   31,  40, 4'b1111, 1'b0, 1, 0};
        tbl[7]  = '{0,   31,  70, 4'b0000, 1'b1, 1, 0};
        tbl[8]  = '{0,   22,  30, 4'b1111, 1'b0, 1, 0};
        tbl[9]  = '{0,   22,  60, 4'b0000, 1'b1, 1, 0};
        tbl[10] = '{1000, 0, 300, 4'b1111, 1'b0, 0, 3};
        tbl[11] = '{0,    0,  28, 4'b1000, 1'b0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            for (int s = 1; s <= tbl[i].n; s++) begin
                step((s > tbl[i].d) && (s != tbl[i].drop_at));
            end
            chk($sformatf("vec%0d_domain_rst", i), int'(domain_rst), int'(tbl[i].dom));
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(tbl[i].rdy));
            chk($sformatf("vec%0d_lock_loss_cnt", i), int'(lock_loss_cnt), tbl[i].ll);
            chk($sformatf("vec%0d_timeout_cnt", i), int'(timeout_cnt), tbl[i].tc);
        end

        // Clean bring-up: pll_rst width and release spacing.
        do_reset();
        nhigh    = 0;
        ready_at = 0;
        for (int k = 0; k < int'(NUM_DOMAINS); k++) rel_at[k] = 0;
        for (int s = 1; s <= 40; s++) begin
            if (pll_rst) nhigh++;
            step(s > 10);
            for (int k = 0; k < int'(NUM_DOMAINS); k++)
                if (!domain_rst[k] && rel_at[k] == 0) rel_at[k] = s;
            if (ready && ready_at == 0) ready_at = s;
        end
        chk("bringup_pll_rst_cycles", nhigh, 4);
        for (int k = 0; k < int'(NUM_DOMAINS); k++)
            chk($sformatf("bringup_release%0d_step", k), rel_at[k], 25 + 4 * k);
        chk("bringup_ready_step", ready_at, 37);

        // Repeated one-cycle drops in RUN: detection latency and counter saturation.
        do_reset();
        for (int l = 0; l < 4; l++) begin
            wait_ready();
            step(1'b0);
            lat = 1;
            while (ready && lat < 10) begin
                step(1'b1);
                lat++;
            end
            chk("loss_latency", lat, int'(SYNC_STAGES) + 1);
            chk("loss_domain_rst", int'(domain_rst), ALL_DOM);
        end
        chk("loss_cnt_saturated", int'(lock_loss_cnt), CNT_MAX);
        wait_ready();

        // Random lock behaviour against the model, with occasional async resets.
        do_reset();
        seg_left = 0;
        lvl      = 1'b0;
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if (seg_left == 0) begin
                case ($urandom_range(0, 9))
                    0, 1: begin lvl = 1'b0; seg_left = int'($urandom_range(1, 3)); end
                    2:    begin lvl = 1'b0; seg_left = int'($urandom_range(40, 70)); end
                    default: begin lvl = 1'b1; seg_left = int'($urandom_range(5, 60)); end
                endcase
            end
            step(lvl);
            seg_left--;
        end
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
